// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: issue-side interlock for the in-order pipeline.
// Tracks, per register class (P, I, F) and register, the cycles left until an
// in-flight result becomes forwardable. The block stalls ID on RAW, on WAW
// (to keep write-back in order) and on a busy unpipelined FPU.
// Optional feature macro: SB_FPU_PIPE_EN (defined = pipelined FPU, no
// structural FPU stall; undefined = unpipelined FPU tracked by fpu_cnt).
module hazard_scoreboard #(
    parameter int unsigned NREG    = 16,
    parameter int unsigned FPU_LAT = 4,
    parameter int unsigned LD_LAT  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [3:0]      id_src1,
    input  logic [2:0]      id_src1_cls,
    input  logic [3:0]      id_src2,
    input  logic [2:0]      id_src2_cls,
    input  logic [3:0]      id_dst,
    input  logic [2:0]      id_dst_cls,
    input  logic [1:0]      id_kind,
    input  logic            flush,
    output logic            stall,
    output logic [NREG-1:0] busy_p,
    output logic [NREG-1:0] busy_i,
    output logic [NREG-1:0] busy_f,
    output logic [15:0]     stall_cnt
);

    localparam int unsigned IW      = 4;
    localparam logic [1:0]  KindLd  = 2'b01;
    localparam logic [1:0]  KindFpu = 2'b10;
    localparam logic [2:0]  ClsP    = 3'b001;
    localparam logic [2:0]  ClsI    = 3'b010;
    localparam logic [2:0]  ClsF    = 3'b100;
    localparam logic [3:0]  LdLm1   = 4'(LD_LAT - 1);
    localparam logic [3:0]  FpuLm1  = 4'(FPU_LAT - 1);

    // Latencies must fit the 4-bit counters and exceed one cycle.
    if (FPU_LAT < 2 || FPU_LAT > 15) begin : g_bad_fpu_lat
        $error("FPU_LAT out of range 2..15");
    end
    if (LD_LAT < 2 || LD_LAT > 15) begin : g_bad_ld_lat
        $error("LD_LAT out of range 2..15");
    end

    logic [3:0]  cnt_p_q [NREG];
    logic [3:0]  cnt_i_q [NREG];
    logic [3:0]  cnt_f_q [NREG];
    logic [3:0]  cnt_p_d [NREG];
    logic [3:0]  cnt_i_d [NREG];
    logic [3:0]  cnt_f_d [NREG];
    logic [3:0]  fpu_cnt;
    logic [15:0] stall_cnt_q;

    logic [3:0]  src1_pend;
    logic [3:0]  src2_pend;
    logic [3:0]  dst_pend;
    logic [3:0]  lat_m1;
    logic        dst_we;
    logic        raw1;
    logic        raw2;
    logic        waw;
    logic        fpu_struct;
    logic        issue;
    logic        load_p;
    logic        load_i;
    logic        load_f;

    // Pending counts seen by each operand; non-one-hot classes never match.
    always_comb begin
        src1_pend = '0;
        src2_pend = '0;
        dst_pend  = '0;
        dst_we    = 1'b0;
        unique case (id_src1_cls)
            ClsP:    src1_pend = cnt_p_q[id_src1];
            ClsI:    src1_pend = cnt_i_q[id_src1];
            ClsF:    src1_pend = cnt_f_q[id_src1];
            default: src1_pend = '0;
        endcase
        unique case (id_src2_cls)
            ClsP:    src2_pend = cnt_p_q[id_src2];
            ClsI:    src2_pend = cnt_i_q[id_src2];
            ClsF:    src2_pend = cnt_f_q[id_src2];
            default: src2_pend = '0;
        endcase
        unique case (id_dst_cls)
            ClsP: begin
                dst_pend = cnt_p_q[id_dst];
                dst_we   = 1'b1;
            end
            ClsI: begin
                dst_pend = cnt_i_q[id_dst];
                dst_we   = 1'b1;
            end
            ClsF: begin
                dst_pend = cnt_f_q[id_dst];
                dst_we   = 1'b1;
            end
            default: begin
                dst_pend = '0;
                dst_we   = 1'b0;
            end
        endcase
    end

    // Result latency minus one for the ID instruction; kind 11 acts as single-cycle.
    always_comb begin
        lat_m1 = '0;
        unique case (id_kind)
            KindLd:  lat_m1 = LdLm1;
            KindFpu: lat_m1 = FpuLm1;
            default: lat_m1 = '0;
        endcase
    end

    // Hazard detection and issue qualification.
    always_comb begin
        raw1       = (src1_pend != '0);
        raw2       = (src2_pend != '0);
        waw        = dst_we && (lat_m1 < dst_pend);
        fpu_struct = (id_kind == KindFpu) && (fpu_cnt != '0);
        stall      = id_valid && !flush && (raw1 || raw2 || waw || fpu_struct);
        issue      = id_valid && !stall && !flush;
        load_p     = issue && (id_dst_cls == ClsP);
        load_i     = issue && (id_dst_cls == ClsI);
        load_f     = issue && (id_dst_cls == ClsF);
    end

    // Counter next state: saturating decrement, issue load takes priority.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_p_d[r] = (cnt_p_q[r] != '0) ? cnt_p_q[r] - 4'd1 : 4'd0;
            cnt_i_d[r] = (cnt_i_q[r] != '0) ? cnt_i_q[r] - 4'd1 : 4'd0;
            cnt_f_d[r] = (cnt_f_q[r] != '0) ? cnt_f_q[r] - 4'd1 : 4'd0;
            if (load_p && (id_dst == IW'(r))) cnt_p_d[r] = lat_m1;
            if (load_i && (id_dst == IW'(r))) cnt_i_d[r] = lat_m1;
            if (load_f && (id_dst == IW'(r))) cnt_f_d[r] = lat_m1;
        end
    end

    // Per-register pending counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_p_q[r] <= '0;
                cnt_i_q[r] <= '0;
                cnt_f_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_p_q[r] <= cnt_p_d[r];
                cnt_i_q[r] <= cnt_i_d[r];
                cnt_f_q[r] <= cnt_f_d[r];
            end
        end
    end

`ifdef SB_FPU_PIPE_EN
    // Pipelined FPU accepts an op every cycle, so no occupancy is tracked.
    assign fpu_cnt = '0;
`else
    logic [3:0] fpu_cnt_q;

    // Unpipelined FPU occupancy: reloaded on every FPU issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpu_cnt_q <= '0;
        end else if (issue && (id_kind == KindFpu)) begin
            fpu_cnt_q <= FpuLm1;
        end else if (fpu_cnt_q != '0) begin
            fpu_cnt_q <= fpu_cnt_q - 4'd1;
        end
    end

    assign fpu_cnt = fpu_cnt_q;
`endif

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;

    // Busy flags depend on state only, never on the ID inputs.
    always_comb begin
        busy_p = '0;
        busy_i = '0;
        busy_f = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_p[r] = (cnt_p_q[r] != '0);
            busy_i[r] = (cnt_i_q[r] != '0);
            busy_f[r] = (cnt_f_q[r] != '0);
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Issue-side interlock for the in-order pipeline. It records, per register class (P, I, F) and per register, how many cycles remain until an in-flight result can be forwarded. It then stalls the ID stage when a source or destination collides with a pending result. The forwarding-select logic covers every result whose count has reached zero, and this block covers the rest: load-use bubbles, multi-cycle FPU results and write ordering.

## Interface
Parameters:
- `NREG`, 16 — registers per class; index width is 4 bits.
- `FPU_LAT`, 4 — FPU result latency in cycles, range 2..15.
- `LD_LAT`, 2 — load result latency in cycles, range 2..15.

Ports:
- `clk` — in, 1. Single clock; all state updates on the rising edge.
- `rst_n` — in, 1. Reset is asynchronous and active-low.
- `id_valid` — in, 1. ID stage holds an instruction.
- `id_src1`, `id_src2` — in, 4 each. Source register indices.
- `id_src1_cls`, `id_src2_cls` — in, 3 each. Source class, one-hot: [2] F, [1] I, [0] P; 000 = source unused.
- `id_dst` — in, 4. Destination register index.
- `id_dst_cls` — in, 3. Destination class, one-hot; 000 = no write.
- `id_kind` — in, 2. 00 single-cycle, 01 load, 10 FPU, 11 is treated as 00.
- `flush` — in, 1. Kill the ID-stage instruction this cycle.
- `stall` — out, 1. Hold ID and insert a bubble into EX.
- `busy_p`, `busy_i`, `busy_f` — out, 16 each. Bit r = 1 when the pending counter of register r in that class is nonzero.
- `stall_cnt` — out, 16. Saturating count of stall cycles.

## Operation
- State: one 4-bit down-counter `cnt[cls][r]` per class and register (48 total), plus `fpu_cnt` (4 bits).
- Issue condition: `id_valid & ~stall & ~flush`.
- On issue with a nonzero `id_dst_cls`, load `cnt[dst_cls][id_dst]` with L-1:
  - L = 1 for single-cycle, so the value loaded is 0 (no tracking);
  - L = `LD_LAT` for loads;
  - L = `FPU_LAT` for FPU ops.
- Every other nonzero counter decrements by 1 per cycle and saturates at 0.
- If the same entry is both issued to and decremented in one cycle, the issue load wins.
- RAW stall: for a source with nonzero class, `cnt[src_cls][src] != 0` raises `stall`.
- WAW stall: the issuing instruction's L-1 is less than the current `cnt[dst_cls][id_dst]` raises `stall`. This keeps write-back in order.
- `stall` = `id_valid & (RAW1 | RAW2 | WAW | FPU structural)`. It is forced to 0 when `flush=1`.
- `flush` affects only the ID instruction. Entries already in flight keep counting down.
- Class bits are compared only when both sides are one-hot and equal. A source in I never matches a pending P entry with the same index.
- `stall_cnt` increments on each cycle where `stall=1` and holds at 0xFFFF.

## Timing
- `stall` is combinational from the ID inputs and the current state, with the same-cycle response ID requires.
- Counter and busy updates appear on the edge after issue. `busy_*` outputs are registered-derived, with no combinational path from the ID inputs.
- Load followed immediately by a dependent consumer (`LD_LAT`=2): exactly 1 stall cycle. A consumer 2 or more cycles later: no stall.
- FPU followed by a dependent consumer (`FPU_LAT`=4): 3 stall cycles.
- Reset (asserted asynchronously at any time, including mid-countdown): all `cnt` entries, `fpu_cnt` and `stall_cnt` go to 0. Consequently `busy_*` = 0 and `stall` = 0.
- After `rst_n` rises, the first edge may issue.

## Configuration
- `SB_FPU_PIPE_EN`:
  - Defined: the FPU is pipelined. Back-to-back independent FPU ops issue without stalling, and `fpu_cnt` is unused (tied 0).
  - Undefined: the FPU is unpipelined.
    - An FPU issue loads `fpu_cnt` with `FPU_LAT`-1.
    - Any FPU-kind instruction in ID stalls while `fpu_cnt != 0`.
    - Non-FPU instructions are unaffected.

## Test plan
- Reset check: pulse `rst_n` low mid-FPU countdown. Require `busy_f`=0, `stall`=0 and `stall_cnt`=0 asynchronously, and no stall for a dependent reader on the first cycle after release.
- Load-use: load I3, then the next cycle an add reading I3 as src1. Require `stall`=1 for exactly 1 cycle, `busy_i[3]` high for 1 cycle, and `stall_cnt`=1.
- Class isolation: FPU writes F5, then an instruction reads P5 and I5. Require `stall`=0 and `busy_f[5]`=1 for 3 cycles.
- FPU RAW: FPU writes F2, then a reader of F2. Require 3 stall cycles, with issue on the 4th cycle.
- WAW plus flush:
  - FPU writes F1, then a load writes F1 one cycle later. Require a stall until `cnt[F][1]` ≤ 1.
  - With `flush`=1 on the same cycle, require `stall`=0 and `cnt` unchanged.
- Structural: two independent FPU ops back-to-back.
  - With `SB_FPU_PIPE_EN`: 0 stalls.
  - Without it: 3 stalls, and `stall_cnt`=3.
